// File: rtl/game_pkg.sv
// Shared arena-game types and defaults: headings, player states, cell
// coordinate width and the default arena geometry.
package game_pkg;

    localparam int CELL_W = 7;

    localparam int unsigned DEF_CELL         = 8;
    localparam int unsigned DEF_GRID_W       = 80;
    localparam int unsigned DEF_GRID_H       = 60;
    localparam int unsigned DEF_BORDER_CELLS = 2;
    localparam int unsigned DEF_START_X      = 27;
    localparam int unsigned DEF_START_Y      = 29;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_UP    = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        WAIT = 2'd0,
        RUN  = 2'd1,
        DEAD = 2'd2
    } player_state_t;

    // One-cell displacement along x for a heading.
    function automatic logic signed [7:0] delta_x(dir_t d);
        case (d)
            DIR_RIGHT: delta_x = 8'sd1;
            DIR_LEFT:  delta_x = -8'sd1;
            default:   delta_x = 8'sd0;
        endcase
    endfunction

    // One-cell displacement along y for a heading (y grows downwards).
    function automatic logic signed [7:0] delta_y(dir_t d);
        case (d)
            DIR_DOWN: delta_y = 8'sd1;
            DIR_UP:   delta_y = -8'sd1;
            default:  delta_y = 8'sd0;
        endcase
    endfunction

endpackage

// File: rtl/key_edge.sv
// Key front end: 2-flop synchronisers, falling-edge detect and release
// tracking for the two active-low rotation keys.
module key_edge (
    input  logic clk,
    input  logic reset,
    input  logic key_cw,
    input  logic key_ccw,
    output logic press_cw,
    output logic press_ccw
);

    // Bit 0 is cw, bit 1 is ccw; 0 means the key is held.
    logic [1:0] sync1_q, sync2_q, prev_q;
    logic       armed_q, armed_d;
    logic [1:0] fall;

    // Synchroniser chain and release tracker; reset treats both keys as held.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
            prev_q  <= 2'b00;
            armed_q <= 1'b0;
        end else begin
            sync1_q <= {key_ccw, key_cw};
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            armed_q <= armed_d;
        end
    end

    // Edge detect; a simultaneous press of both keys disarms without turning.
    always_comb begin
        fall      = prev_q & ~sync2_q;
        press_cw  = armed_q & fall[0] & ~fall[1];
        press_ccw = armed_q & fall[1] & ~fall[0];
        armed_d   = armed_q ? ~|fall : &sync2_q;
    end

endmodule

// File: rtl/player_cycle.sv
// Light-cycle player engine: head position, stepping, turns, collisions
// and head rendering on the pixel clock.
// Build option PLAYER_WRAP_EN: the border wraps to the opposite interior
// edge instead of killing the player.
module player_cycle
    import game_pkg::*;
#(
    parameter int unsigned CELL         = DEF_CELL,
    parameter int unsigned GRID_W       = DEF_GRID_W,
    parameter int unsigned GRID_H       = DEF_GRID_H,
    parameter int unsigned BORDER_CELLS = DEF_BORDER_CELLS,
    parameter int unsigned START_X      = DEF_START_X,
    parameter int unsigned START_Y      = DEF_START_Y,
    parameter int unsigned START_DIR    = 0,
    parameter int unsigned STEP_TICKS   = 1000000,
    parameter int unsigned COLOR_R      = 255,
    parameter int unsigned COLOR_G      = 255,
    parameter int unsigned COLOR_B      = 0
) (
    input  logic              VGA_CLK,
    input  logic              reset,
    input  logic              restart,
    input  logic              key_ccw,
    input  logic              key_cw,
    input  logic              blocked,
    input  logic [9:0]        next_x,
    input  logic [9:0]        next_y,
    output logic [7:0]        OUT_R,
    output logic [7:0]        OUT_G,
    output logic [7:0]        OUT_B,
    output logic [CELL_W-1:0] head_x,
    output logic [CELL_W-1:0] head_y,
    output logic [CELL_W-1:0] target_x,
    output logic [CELL_W-1:0] target_y,
    output logic [1:0]        dir,
    output logic              step,
    output logic              alive
);

    localparam int unsigned CNT_W = $clog2(STEP_TICKS);
    localparam int unsigned SHIFT = $clog2(CELL);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_TICKS - 1);

    localparam logic signed [7:0] X_LO   = 8'(BORDER_CELLS);
    localparam logic signed [7:0] X_HI   = 8'(GRID_W - BORDER_CELLS);
    localparam logic signed [7:0] Y_LO   = 8'(BORDER_CELLS);
    localparam logic signed [7:0] Y_HI   = 8'(GRID_H - BORDER_CELLS);
`ifdef PLAYER_WRAP_EN
    localparam logic signed [7:0] X_MAX  = 8'(GRID_W - BORDER_CELLS - 1);
    localparam logic signed [7:0] Y_MAX  = 8'(GRID_H - BORDER_CELLS - 1);
`endif

    localparam logic [7:0] COL_R = 8'(COLOR_R);
    localparam logic [7:0] COL_G = 8'(COLOR_G);
    localparam logic [7:0] COL_B = 8'(COLOR_B);

    player_state_t     state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CELL_W-1:0] head_x_q, head_x_d, head_y_q, head_y_d;
    dir_t              dir_q, dir_d;
    // Pending turn as a mod-4 offset: 0 none, 1 cw, 3 ccw.
    logic [1:0]        turn_q, turn_d;

    logic              game_reset;
    logic              press_cw, press_ccw, any_press;
    logic [1:0]        new_turn;
    dir_t              eff_dir;
    logic signed [7:0] hx_s, hy_s, tx_raw, ty_raw, tx, ty;
    logic              x_low, x_high, y_low, y_high, out_of_arena;
    logic              step_ev, hit;

    assign game_reset = reset | restart;

    key_edge u_key_edge (
        .clk       (VGA_CLK),
        .reset     (game_reset),
        .key_cw    (key_cw),
        .key_ccw   (key_ccw),
        .press_cw  (press_cw),
        .press_ccw (press_ccw)
    );

    assign any_press = press_cw | press_ccw;
    assign new_turn  = press_cw ? 2'd1 : 2'd3;

    // Target cell along the effective heading, with border test or wrap.
    always_comb begin
        eff_dir = dir_t'(dir_q + turn_q);
        hx_s    = {1'b0, head_x_q};
        hy_s    = {1'b0, head_y_q};
        tx_raw  = hx_s + delta_x(eff_dir);
        ty_raw  = hy_s + delta_y(eff_dir);
        x_low   = tx_raw < X_LO;
        x_high  = tx_raw >= X_HI;
        y_low   = ty_raw < Y_LO;
        y_high  = ty_raw >= Y_HI;
`ifdef PLAYER_WRAP_EN
        tx           = x_low ? X_MAX : (x_high ? X_LO : tx_raw);
        ty           = y_low ? Y_MAX : (y_high ? Y_LO : ty_raw);
        out_of_arena = 1'b0;
`else
        tx           = tx_raw;
        ty           = ty_raw;
        out_of_arena = x_low | x_high | y_low | y_high;
`endif
    end

    assign target_x = tx[CELL_W-1:0];
    assign target_y = ty[CELL_W-1:0];

    // Game state register; reset and restart restore the start position.
    always_ff @(posedge VGA_CLK) begin
        if (game_reset) begin
            state_q  <= WAIT;
            cnt_q    <= '0;
            head_x_q <= CELL_W'(START_X);
            head_y_q <= CELL_W'(START_Y);
            dir_q    <= dir_t'(2'(START_DIR));
            turn_q   <= 2'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            head_x_q <= head_x_d;
            head_y_q <= head_y_d;
            dir_q    <= dir_d;
            turn_q   <= turn_d;
        end
    end

    // Next-state logic: start on a press, step on the last tick, die on collision.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        head_x_d = head_x_q;
        head_y_d = head_y_q;
        dir_d    = dir_q;
        turn_d   = turn_q;
        step_ev  = 1'b0;
        case (state_q)
            WAIT: begin
                cnt_d = '0;
                if (any_press) begin
                    state_d = RUN;
                    turn_d  = new_turn;
                end
            end
            RUN: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (out_of_arena || blocked) begin
                        state_d = DEAD;
                    end else begin
                        step_ev  = 1'b1;
                        head_x_d = tx[CELL_W-1:0];
                        head_y_d = ty[CELL_W-1:0];
                        dir_d    = eff_dir;
                        // A press on the step cycle is kept for the next step.
                        turn_d   = any_press ? new_turn : 2'd0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (any_press && turn_q == 2'd0) begin
                        turn_d = new_turn;
                    end
                end
            end
            DEAD: begin
            end
            default: state_d = WAIT;
        endcase
    end

    assign step   = step_ev & ~game_reset;
    assign alive  = state_q != DEAD;
    assign head_x = head_x_q;
    assign head_y = head_y_q;
    assign dir    = dir_q;

    // Head painter: full colour while alive, half intensity once dead.
    always_comb begin
        OUT_R = 8'd0;
        OUT_G = 8'd0;
        OUT_B = 8'd0;
        hit   = ((next_x >> SHIFT) == {3'b000, head_x_q}) &&
                ((next_y >> SHIFT) == {3'b000, head_y_q});
        if (hit) begin
            if (state_q == DEAD) begin
                OUT_R = COL_R >> 1;
                OUT_G = COL_G >> 1;
                OUT_B = COL_B >> 1;
            end else begin
                OUT_R = COL_R;
                OUT_G = COL_G;
                OUT_B = COL_B;
            end
        end
    end

endmodule

// File: tb/tb_player_cycle.sv
// Bench for player_cycle: directed scenarios then random keys/blocked/restart,
// with step targets scored against a behavioural game model.
module tb_player_cycle;

    localparam int T  = 4;
    localparam int GW = 80;
    localparam int GH = 60;
    localparam int B  = 2;
    localparam int SX = 27;
    localparam int SY = 29;

    logic       clk = 1'b0;
    logic       reset, restart, key_ccw, key_cw, blocked;
    logic [9:0] next_x, next_y;
    logic [7:0] out_r, out_g, out_b;
    logic [6:0] head_x, head_y, target_x, target_y;
    logic [1:0] dir;
    logic       step, alive;

    always #5 clk = ~clk;

    player_cycle #(.STEP_TICKS(T)) dut (
        .VGA_CLK  (clk),
        .reset    (reset),
        .restart  (restart),
        .key_ccw  (key_ccw),
        .key_cw   (key_cw),
        .blocked  (blocked),
        .next_x   (next_x),
        .next_y   (next_y),
        .OUT_R    (out_r),
        .OUT_G    (out_g),
        .OUT_B    (out_b),
        .head_x   (head_x),
        .head_y   (head_y),
        .target_x (target_x),
        .target_y (target_y),
        .dir      (dir),
        .step     (step),
        .alive    (alive)
    );

    typedef struct {
        int x;
        int y;
    } cell_t;

    cell_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;
    int    obs_steps = 0;
    bit    saw_wrap = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // ---------------- reference model ----------------
    // mode: 0 waiting, 1 running, 2 dead
    int m_mode = 0, m_cnt = 0, m_hx = SX, m_hy = SY, m_dir = 0, m_pend = 0;
    int m_steps = 0;
    bit m_armed = 0;
    bit m_s1_cw = 0, m_s2_cw = 0, m_pv_cw = 0;
    bit m_s1_cc = 0, m_s2_cc = 0, m_pv_cc = 0;

    task automatic m_reset();
        m_mode = 0; m_cnt = 0; m_hx = SX; m_hy = SY; m_dir = 0; m_pend = 0;
        m_steps = 0; m_armed = 0;
        m_s1_cw = 0; m_s2_cw = 0; m_pv_cw = 0;
        m_s1_cc = 0; m_s2_cc = 0; m_pv_cc = 0;
    endtask

    initial begin
        bit fcw, fcc, pcw, pcc, any, off;
        int turn, eff, nx, ny;
        forever begin
            @(posedge clk);
            if (reset || restart) begin
                m_reset();
            end else begin
                // A press is a 1->0 change of the key as seen two clocks late.
                fcw  = m_pv_cw && !m_s2_cw;
                fcc  = m_pv_cc && !m_s2_cc;
                pcw  = m_armed && fcw && !fcc;
                pcc  = m_armed && fcc && !fcw;
                any  = pcw || pcc;
                turn = pcw ? 1 : -1;
                if (m_armed) m_armed = !(fcw || fcc);
                else         m_armed = m_s2_cw && m_s2_cc;
                m_pv_cw = m_s2_cw; m_s2_cw = m_s1_cw; m_s1_cw = key_cw;
                m_pv_cc = m_s2_cc; m_s2_cc = m_s1_cc; m_s1_cc = key_ccw;
                if (m_mode == 0) begin
                    if (any) begin
                        m_mode = 1;
                        m_pend = turn;
                        m_cnt  = 0;
                    end
                end else if (m_mode == 1) begin
                    if (m_cnt == T - 1) begin
                        m_cnt = 0;
                        eff = (m_dir + m_pend + 4) % 4;
                        nx  = m_hx + ((eff == 0) ? 1 : (eff == 2) ? -1 : 0);
                        ny  = m_hy + ((eff == 1) ? 1 : (eff == 3) ? -1 : 0);
                        off = (nx < B) || (nx >= GW - B) || (ny < B) || (ny >= GH - B);
`ifdef PLAYER_WRAP_EN
                        if (nx < B) nx = GW - B - 1;
                        else if (nx >= GW - B) nx = B;
                        if (ny < B) ny = GH - B - 1;
                        else if (ny >= GH - B) ny = B;
                        off = 0;
`endif
                        if (off || blocked) begin
                            m_mode = 2;
                        end else begin
                            exp_q.push_back('{x: nx, y: ny});
                            m_hx = nx; m_hy = ny; m_dir = eff;
                            m_pend = any ? turn : 0;
                            m_steps++;
                        end
                    end else begin
                        m_cnt++;
                        if (any && m_pend == 0) m_pend = turn;
                    end
                end
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        int ox, oy, phx;
        cell_t e;
        forever begin
            @(negedge clk);
            if (step === 1'b1) begin
                ox  = int'(target_x);
                oy  = int'(target_y);
                phx = int'(head_x);
                obs_steps++;
                if (phx == GW - B - 1 && ox == B) saw_wrap = 1;
                @(posedge clk);
                #2;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected step: target (%0d,%0d), none expected", ox, oy);
                end else begin
                    e = exp_q.pop_front();
                    chk("step target_x", ox, e.x);
                    chk("step target_y", oy, e.y);
                    chk("head_x after step", int'(head_x), e.x);
                    chk("head_y after step", int'(head_y), e.y);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int exp_ch(input int px, input int py, input int full);
        if (px / 8 == m_hx && py / 8 == m_hy) return (m_mode == 2) ? full / 2 : full;
        return 0;
    endfunction

    task automatic pix(input string name, input int px, input int py,
                       input int er, input int eg, input int eb);
        next_x = 10'(px);
        next_y = 10'(py);
        #1;
        chk({name, " R"}, int'(out_r), er);
        chk({name, " G"}, int'(out_g), eg);
        chk({name, " B"}, int'(out_b), eb);
    endtask

    task automatic press_key(input bit cw);
        if (cw) key_cw = 1'b0; else key_ccw = 1'b0;
        tick(4);
        key_cw  = 1'b1;
        key_ccw = 1'b1;
        tick(4);
    endtask

    task automatic do_restart();
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        obs_steps = 0;
    endtask

    task automatic model_cmp(input string name);
        chk({name, " head_x"}, int'(head_x), m_hx);
        chk({name, " head_y"}, int'(head_y), m_hy);
        chk({name, " dir"}, int'(dir), m_dir);
        chk({name, " alive"}, int'(alive), (m_mode != 2) ? 1 : 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int guard;
        reset = 1'b1; restart = 1'b0; key_ccw = 1'b1; key_cw = 1'b1;
        blocked = 1'b0; next_x = '0; next_y = '0;
        tick(3);
        reset = 1'b0;

        // Reset state.
        chk("reset head_x", int'(head_x), SX);
        chk("reset head_y", int'(head_y), SY);
        chk("reset dir", int'(dir), 0);
        chk("reset alive", int'(alive), 1);
        pix("reset pixel", 216, 232, 255, 255, 0);

        // 1: idle in WAIT.
        obs_steps = 0;
        tick(100);
        chk("idle no steps", obs_steps, 0);
        chk("idle head_x", int'(head_x), SX);
        chk("idle head_y", int'(head_y), SY);

        // 2: cw press, then stepping downwards every T clocks.
        press_key(1'b1);
        tick(20);
        chk("cw dir", int'(dir), 1);
        chk("cw head_x", int'(head_x), 27);
        chk("cw head_y", int'(head_y), 35);
        model_cmp("cw model");

        // 3: ccw held, cw pressed while ccw still held.
        do_restart();
        tick(5);
        key_ccw = 1'b0;
        tick(20);
        key_cw = 1'b0;
        tick(10);
        chk("held ccw dir", int'(dir), 3);
        key_cw = 1'b1;
        key_ccw = 1'b1;
        tick(12);
        chk("after release dir", int'(dir), 3);
        chk("held ccw head_x", int'(head_x), 27);
        model_cmp("held model");

        // 4: run right into the east border.
        do_restart();
        tick(5);
        press_key(1'b0);
        press_key(1'b1);
`ifdef PLAYER_WRAP_EN
        guard = 0;
        while (!saw_wrap && guard < 800) begin
            tick(1);
            guard++;
        end
        chk("wrap to west edge", int'(saw_wrap), 1);
        chk("wrap alive", int'(alive), 1);
`else
        guard = 0;
        while (alive === 1'b1 && guard < 800) begin
            tick(1);
            guard++;
        end
        chk("border death alive", int'(alive), 0);
        chk("border head_x", int'(head_x), 77);
        tick(12);
        chk("frozen head_x", int'(head_x), 77);
        pix("dead head pixel", 77 * 8, m_hy * 8, 127, 127, 0);
`endif
        model_cmp("border model");

        // 5: blocked on the third step cycle.
        do_restart();
        tick(5);
        press_key(1'b1);
        guard = 0;
        while (!(m_mode == 1 && m_cnt == T - 1 && m_steps == 2) && guard < 100) begin
            tick(1);
            guard++;
        end
        blocked = 1'b1;
        tick(1);
        blocked = 1'b0;
        tick(8);
        chk("blocked alive", int'(alive), 0);
        chk("blocked step count", obs_steps, 2);
        chk("blocked head_y", int'(head_y), 31);

        // 6: restart from DEAD.
        do_restart();
        chk("restart head_x", int'(head_x), SX);
        chk("restart head_y", int'(head_y), SY);
        chk("restart alive", int'(alive), 1);
        chk("restart dir", int'(dir), 0);
        pix("restart px lo", 216, 232, 255, 255, 0);
        pix("restart px hi", 223, 239, 255, 255, 0);
        pix("restart px out", 224, 232, 0, 0, 0);
        tick(20);
        chk("restart waits", obs_steps, 0);

        // Random phase.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) key_cw = ~key_cw;
            if ($urandom_range(0, 7) == 0) key_ccw = ~key_ccw;
            blocked = ($urandom_range(0, 39) == 0);
            restart = (m_mode == 2 && $urandom_range(0, 9) == 0) ||
                      ($urandom_range(0, 499) == 0);
            reset   = ($urandom_range(0, 999) == 0);
            tick(1);
            if (i % 32 == 31) begin
                model_cmp("random");
                pix("random pixel", m_hx * 8 + 3, m_hy * 8 + 5,
                    exp_ch(m_hx * 8 + 3, m_hy * 8 + 5, 255),
                    exp_ch(m_hx * 8 + 3, m_hy * 8 + 5, 255), 0);
            end
        end
        restart = 1'b0;
        reset   = 1'b0;
        blocked = 1'b0;
        tick(3 * T);
        chk("scoreboard drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/player_cycle.md
# player_cycle

Parametrised light-cycle player engine for the arena game. It runs on the pixel clock between the VGA timing generator and the colour mixer. It holds the player head on a cell grid and steps it at a programmable rate, taking rotations from two keys. It detects border and trail collisions, reports the cell being entered so an external trail memory can mark it, and paints the head for the current pixel.

## Interface
Parameters:
- CELL, 8: cell edge in pixels; power of two.
- GRID_W, 80 / GRID_H, 60: arena size in cells; each ≤ 128.
- BORDER_CELLS, 2: width of the lethal frame, in cells.
- START_X, 27 / START_Y, 29: head cell after reset or restart.
- START_DIR, 0: initial heading (0 right, 1 down, 2 left, 3 up).
- STEP_TICKS, 1000000: clocks per step; ≥ 2.
- COLOR_R, 255 / COLOR_G, 255 / COLOR_B, 0: head colour.

Ports:
- VGA_CLK  in  1  sole clock.
- reset  in  1  synchronous, active-high; full reset.
- restart  in  1  synchronous, active-high; same effect as reset on game state.
- key_ccw  in  1  active-low counter-clockwise key (asynchronous to the clock).
- key_cw  in  1  active-low clockwise key (asynchronous to the clock).
- blocked  in  1  trail memory reports that cell target_x/target_y is occupied; sampled on step cycles.
- next_x, next_y  in  10  pixel coordinate to colour.
- OUT_R, OUT_G, OUT_B  out  8 each  head colour or 0.
- head_x, head_y  out  7 each  current head cell.
- target_x, target_y  out  7 each  cell the next step enters; combinational.
- dir  out  2  current heading.
- step  out  1  one-cycle pulse when the head moves; the trail memory writes head_x/head_y on it.
- alive  out  1  low after a collision.

## Operation
- Keys pass through a 2-flop synchroniser. A press is the 1→0 edge of the synchronised key.
- A press is accepted only when both keys have been released since the last accepted press.
- An accepted press sets pending_turn (+1 for cw, −1 for ccw). A press arriving while a turn is already pending is ignored.
- Both keys pressed on the same cycle, with both previously released: no turn. The keys are still considered held.
- Heading arithmetic is modulo 4.
- Effective heading = dir + pending_turn. target_x/target_y = head moved one cell along the effective heading, in 8-bit signed arithmetic, truncated to 7 bits.
- State machine:
  - WAIT: head drawn, no motion, tick counter held at 0. Any accepted press → RUN. That press also sets pending_turn.
  - RUN: counter counts 0..STEP_TICKS−1. At STEP_TICKS−1 the step evaluation below runs and the counter returns to 0.
  - DEAD: alive=0, head frozen, keys ignored. Leaves only on reset or restart.
- Step evaluation in RUN:
  - The target is out of arena when x < BORDER_CELLS, x ≥ GRID_W−BORDER_CELLS, or the same test on y with GRID_H.
  - Out of arena or blocked=1 → DEAD, no step pulse, head unchanged.
  - Otherwise head ← target, dir ← effective heading, pending_turn ← 0, step=1.
- Render: OUT = COLOR when next_x/CELL == head_x and next_y/CELL == head_y, else 0. In DEAD the head is painted at half intensity (each channel >>1).

## Timing
- Reset/restart values: head = (START_X, START_Y), dir = START_DIR, state WAIT, alive=1, step=0, counter=0, pending_turn=0, both keys treated as held. OUT follows immediately from those values.
- Key latency: a press is visible as pending_turn 3 clocks after the key pin falls.
- First step: STEP_TICKS clocks after entry to RUN.
- Steps then occur every STEP_TICKS clocks.
- head_x, head_y and dir update on the clock edge that ends the step cycle; step is high during that cycle.
- A press landing on the step cycle applies to the following step.
- reset or restart asserted on a step cycle: reset wins; no step pulse.
- Render is combinational from registered state. No added pipeline latency.

## Configuration
- PLAYER_WRAP_EN defined:
  - The border is not lethal. Leaving the arena re-enters at the opposite interior edge: x < BORDER_CELLS → GRID_W−BORDER_CELLS−1, and symmetrically for the other three edges.
  - target_x/target_y report the wrapped cell.
  - blocked still kills.
- Undefined: the border kills as described in Operation.

## Structure
- Shared package game_pkg holds:
  - dir_t with DIR_RIGHT=0, DIR_DOWN=1, DIR_LEFT=2, DIR_UP=3.
  - player_state_t with WAIT, RUN, DEAD.
  - CELL_W=7.
  - Default arena constants.
- Sub-module key_edge: synchroniser, edge detect and release tracking for both keys. Outputs press_cw and press_ccw.

## Test plan
Directed scenarios, all with STEP_TICKS=4 and defaults otherwise:
1. Reset, no keys for 100 clocks → head (27,29), state WAIT, step never high.
2. cw pressed and released → heading 1. Steps every 4 clocks; head (27,30), (27,31)…
3. ccw held for 20 clocks, then cw pressed without releasing ccw → exactly one turn (heading 3). The cw press is ignored until both keys are released.
4. Heading right from (75,29) → steps to (76,29) and (77,29). The next evaluation targets 78 → alive=0, head stays (77,29), no step pulse, OUT channels at half intensity. With PLAYER_WRAP_EN the head goes to (2,29) instead.
5. blocked=1 forced on the 3rd step cycle → DEAD, exactly 2 step pulses observed.
6. restart pulsed while in DEAD → head (27,29), alive=1, WAIT. Pixel (216..223, 232..239) returns (255,255,0); pixel (224,232) returns 0.
